sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single 16-bit SDRAM controller (burst-4 reads, 64-bit dout) among NPORTS requesters (68k, Z80, sprite fetch).
//  Per-port req/ack handshake in front of the controller's edge-triggered rd/we strobes and ready_first/ready_fourth flags.
//  Serializes accesses, routes address/data/byte-enables, returns 64-bit read bursts with a one-cycle ack to the granted port.
// PARAMETERS
//  NPORTS   3   number of requesters; port 0 highest fixed priority
//  ADDR_W  25   byte address width, matches controller addr
// PORTS
//  clk          in   1            system clock, same domain as SDRAM controller
//  nreset       in   1            asynchronous active-low reset
//  p_req        in   NPORTS       level request, held until p_ack
//  p_we         in   NPORTS       1=write, 0=read; stable while p_req
//  p_addr       in   NPORTS*ADDR_W byte address per port
//  p_din        in   NPORTS*16    write data per port
//  p_wtbt       in   NPORTS*2     byte-enable per port (controller wtbt encoding)
//  p_ack        out  NPORTS       one-cycle completion pulse, one-hot
//  p_dout       out  64           read burst {w0,w1,w2,w3}; valid in p_ack cycle
//  sd_addr/sd_din/sd_wtbt  out  ADDR_W/16/2  to controller, registered
//  sd_rd, sd_we out   1           level strobes; controller acts on rising edge
//  sd_dout      in   64           controller burst data
//  sd_rdy1      in   1            controller ready_first
//  sd_rdy4      in   1            controller ready_fourth
// BEHAVIOUR
//  Reset: state=IDLE, sd_rd=sd_we=0, sd_addr/din/wtbt=0, p_ack=0, p_dout=0, grant=0, rr pointer=0.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> GAP -> IDLE.
//  IDLE: no ready gating (controller queues edges). If any p_req: latch grant g; register sd_addr/din/wtbt from port g;
//    raise sd_we if p_we[g] else sd_rd; go ISSUE.
//  ISSUE: hold strobe exactly 2 clocks (controller samples edge, drops ready) -> WAIT.
//  WAIT: read completes on sd_rdy4=1, write on sd_rdy1=1; hold strobe until then.
//    Read cache hit (same 16-bit word, controller keeps sd_rdy4=1) completes at first WAIT cycle.
//  DONE: p_ack[g]=1 for 1 clock; p_dout<=sd_dout captured in the WAIT completion cycle (write: p_dout unchanged);
//    drop sd_rd/sd_we.
//  GAP: 1 clock, strobes low, guarantees next rising edge is visible. Min turnaround = 6 clocks + controller latency.
//  Requester must drop p_req the clock after p_ack; p_req still high in IDLE = new transaction.
//  p_req dropped before ack: transaction still completes, ack still pulses (no abort).
//  p_we/p_addr changes while granted: ignored (values latched in IDLE).
//  Simultaneous requests: grant by priority encoder; non-granted ports wait, no starvation guarantee in fixed mode.
//  Async reset mid-transaction: immediate IDLE, strobes low, no ack; controller is not reset by this block.
//  Widths: p_addr slice g = p_addr[g*ADDR_W +: ADDR_W]; same indexing for din/wtbt.
// CONFIGURATION
//  SDRAM_ARB_ROUND_ROBIN_EN defined: rotating priority; search starts at port (last_grant+1) mod NPORTS;
//    pointer updates in DONE.
//  Not defined: fixed priority, lowest index wins; rr pointer logic absent.
// STRUCTURE
//  Package sdram_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE, GAP), ISSUE_CYCLES=2, port index type $clog2(NPORTS).
//  Sub-module sdram_arb_grant: combinational req vector + start index -> one-hot grant and index; shared by both modes.
// TESTING
//  1 Port1 read 0x000100, model returns 64'h1111_2222_3333_4444 -> sd_rd rises once, p_ack=3'b010 for 1 clk, p_dout matches.
//  2 Port0 write 16'hBEEF wtbt=2'b11 at 0x000200 -> sd_we rises, sd_din=BEEF, ack on sd_rdy1, p_ack=3'b001, p_dout unchanged.
//  3 All 3 ports request same clock, fixed mode -> grant order 0,1,2; with ROUND_ROBIN_EN after last grant 0 -> 1,2,0.
//  4 Port2 re-reads 0x000100 with controller hit (sd_rdy4 stays 1) -> ack at first WAIT, no hang, 6-clk turnaround.
//  5 nreset low during WAIT -> strobes 0 same cycle, no p_ack; next request after release served normally.
//  6 Back-to-back reads port0 -> sd_rd low >=1 clk between transactions; two distinct rising edges seen by model.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Optional feature macro: SDRAM_ARB_ROUND_ROBIN_EN (rotating priority).
package sdram_arb_pkg;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        GAP
    } arb_state_t;

    // The strobe is held this many clocks before completion flags are trusted.
    // The controller needs them to see the edge and drop its ready flags.
    localparam int ISSUE_CYCLES  = 2;
    localparam int NPORTS_DEFAULT = 3;

    // Index width for a port number, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(NPORTS_DEFAULT)-1:0] port_idx_t;

endpackage

// File: rtl/sdram_arb_grant.sv
// Combinational grant picker: scans the request vector starting at 'start',
// wrapping around, and returns the first requester as one-hot plus index.
// Fixed priority passes start=0; rotating priority passes last_grant+1.
module sdram_arb_grant
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int IDX_W  = idx_width(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic              any,
    output logic [NPORTS-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    // First requester found on the wrapped scan wins.
    always_comb begin
        int pos;
        pos = 0;
        any = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
            pos = (int'(start) + k) % NPORTS;
            if (!any && req[IDX_W'(pos)]) begin
                any               = 1'b1;
                gnt[IDX_W'(pos)]  = 1'b1;
                idx               = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one burst-4 SDRAM controller among NPORTS req/ack requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE -> GAP -> IDLE.
// Strobes are levels; the controller acts on their rising edge, so a gap of
// low cycles is always left between transactions.
// Optional feature macro: SDRAM_ARB_ROUND_ROBIN_EN selects rotating priority;
// without it port 0 always has the highest priority.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int ADDR_W = 25
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [NPORTS-1:0]        p_req,
    input  logic [NPORTS-1:0]        p_we,
    input  logic [NPORTS*ADDR_W-1:0] p_addr,
    input  logic [NPORTS*16-1:0]     p_din,
    input  logic [NPORTS*2-1:0]      p_wtbt,
    output logic [NPORTS-1:0]        p_ack,
    output logic [63:0]              p_dout,
    output logic [ADDR_W-1:0]        sd_addr,
    output logic [15:0]              sd_din,
    output logic [1:0]               sd_wtbt,
    output logic                     sd_rd,
    output logic                     sd_we,
    input  logic [63:0]              sd_dout,
    input  logic                     sd_rdy1,
    input  logic                     sd_rdy4
);

    localparam int IDX_W = idx_width(NPORTS);
    localparam int CNT_W = $clog2(ISSUE_CYCLES + 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [NPORTS-1:0] grant_oh;
    logic              is_wr;
    logic              done_now;

    logic [IDX_W-1:0]  search_start;
    logic              cand_any;
    logic [NPORTS-1:0] cand_oh;
    logic [IDX_W-1:0]  cand_idx;

    // Per-port views of the flattened request buses.
    logic [ADDR_W-1:0] addr_a [NPORTS];
    logic [15:0]       din_a  [NPORTS];
    logic [1:0]        wtbt_a [NPORTS];

    for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
        assign addr_a[i] = p_addr[i*ADDR_W +: ADDR_W];
        assign din_a[i]  = p_din[i*16 +: 16];
        assign wtbt_a[i] = p_wtbt[i*2 +: 2];
    end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_last;

    // Remember the port served last; the next search begins just after it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            rr_last <= '0;
        else if (state == DONE)
            rr_last <= grant_idx;
    end

    // Index of the granted port, needed only to advance the rotation.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            grant_idx <= '0;
        else if (state == IDLE && cand_any)
            grant_idx <= cand_idx;
    end

    assign search_start = (rr_last == IDX_W'(NPORTS - 1)) ? '0 : rr_last + 1'b1;
`else
    assign search_start = '0;
`endif

    sdram_arb_grant #(
        .NPORTS (NPORTS),
        .IDX_W  (IDX_W)
    ) u_grant (
        .req    (p_req),
        .start  (search_start),
        .any    (cand_any),
        .gnt    (cand_oh),
        .idx    (cand_idx)
    );

    // Reads finish on the fourth word, writes as soon as the first is taken.
    // A read cache hit keeps sd_rdy4 high, so it finishes on the first WAIT cycle.
    assign done_now = (state == WAIT) && (is_wr ? sd_rdy1 : sd_rdy4);

    // Transaction sequencer; every controller- and requester-facing output
    // is a register written here.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            issue_cnt <= '0;
            grant_oh  <= '0;
            is_wr     <= 1'b0;
            sd_addr   <= '0;
            sd_din    <= '0;
            sd_wtbt   <= '0;
            sd_rd     <= 1'b0;
            sd_we     <= 1'b0;
            p_ack     <= '0;
            p_dout    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The controller queues edges itself, so no ready gating here.
                    if (cand_any) begin
                        grant_oh  <= cand_oh;
                        is_wr     <= p_we[cand_idx];
                        sd_addr   <= addr_a[cand_idx];
                        sd_din    <= din_a[cand_idx];
                        sd_wtbt   <= wtbt_a[cand_idx];
                        sd_we     <= p_we[cand_idx];
                        sd_rd     <= ~p_we[cand_idx];
                        issue_cnt <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Ready flags are stale until the controller has seen the edge.
                    if (issue_cnt == CNT_W'(ISSUE_CYCLES - 1))
                        state <= WAIT;
                    else
                        issue_cnt <= issue_cnt + 1'b1;
                end
                WAIT: begin
                    if (done_now) begin
                        if (!is_wr)
                            p_dout <= sd_dout;
                        p_ack <= grant_oh;
                        sd_rd <= 1'b0;
                        sd_we <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    p_ack <= '0;
                    state <= GAP;
                end
                GAP: begin
                    // One more low cycle so the next rising edge is unambiguous.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (!nreset) $onehot0(p_ack));
    a_one_strobe: assert property (@(posedge clk) disable iff (!nreset) !(sd_rd && sd_we));

endmodule
